// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
// Converts whole FFT output frames into a one-sample-per-beat valid/ready stream.
// Two frame buffers are used in ping-pong fashion. Frames are written alternately
// into buf0 and buf1 and are read back in the order they arrived.
// When both buffers are full, any frame offered is dropped and the sticky
// overflow flag is set.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | nothing to send; waiting for the buffer at rd_sel to fill
// S_STREAM | presenting buf[rd_sel] sample idx; advances on m_ready
module fft_frame_serializer #(
    parameter int N      = 16,
    parameter int W      = 16,
    parameter int BITREV = 0,
    localparam int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_valid,
    input  logic [N*W-1:0]     frame_r,
    input  logic [N*W-1:0]     frame_i,
    output logic               frame_ready,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W-1:0]       m_data_r,
    output logic [W-1:0]       m_data_i,
    output logic [IDX_W-1:0]   m_index,
    output logic               m_last,
    output logic               overflow,
    input  logic               ovf_clr
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t             state;
    state_t             state_nxt;

    logic [N*W-1:0]     buf_r [2];
    logic [N*W-1:0]     buf_i [2];
    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic               wr_sel;
    logic               rd_sel;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   slot;

    logic               capture;
    logic               drop;
    logic               beat;
    logic               frm_done;

    // The stage-4 output order is the bit-reversed bin index. When BITREV is set,
    // bin k is found by reading slot bitrev(k).
    function automatic logic [IDX_W-1:0] bit_reverse(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int b = 0; b < IDX_W; b++) begin
            r[b] = v[IDX_W-1-b];
        end
        return r;
    endfunction

    // frame_ready depends only on the registered full flags. This keeps
    // frame_valid and m_ready off any combinational path to it.
    assign frame_ready = ~(full[0] & full[1]);
    assign capture     = frame_valid & frame_ready;
    assign drop        = frame_valid & ~frame_ready;

    assign m_valid     = (state == S_STREAM);
    assign beat        = m_valid & m_ready;
    assign frm_done    = beat & (idx == IDX_LAST);

    // The output is a plain mux driven by registered state. During a stall,
    // rd_sel and idx do not change. The buffer being read is full, so it is
    // never the one being written. Together these keep the output stable.
    assign slot        = (BITREV != 0) ? bit_reverse(idx) : idx;
    assign m_data_r    = buf_r[rd_sel][int'(slot)*W +: W];
    assign m_data_i    = buf_i[rd_sel][int'(slot)*W +: W];
    assign m_index     = idx;
    assign m_last      = m_valid & (idx == IDX_LAST);

    // Full-flag update. Release and capture can happen on the same edge;
    // they always affect different buffers, so both take effect.
    always_comb begin
        full_nxt = full;
        if (frm_done) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (capture) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM next state. A frame is followed directly by the next one only
    // if the other buffer was already full before this edge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (full[rd_sel]) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (frm_done && !full[!rd_sel]) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Frame storage. A capture writes the complete frame in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                buf_r[b] <= '0;
                buf_i[b] <= '0;
            end
        end else if (capture) begin
            buf_r[wr_sel] <= frame_r;
            buf_i[wr_sel] <= frame_i;
        end
    end

    // Buffer pointers, full flags and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            idx    <= '0;
        end else begin
            full <= full_nxt;
            if (capture) begin
                wr_sel <= ~wr_sel;
            end
            if (beat) begin
                if (frm_done) begin
                    idx    <= '0;
                    rd_sel <= ~rd_sel;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Sticky drop flag. If a frame is dropped in the same cycle as a clear,
    // the flag stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Testbench for fft_frame_serializer. A natural-order instance and a BITREV
// instance receive the same stimulus. A reference model made of queues
// predicts frame acceptance, the stream order and the overflow flag.
module tb_fft_frame_serializer;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           frame_valid = 1'b0;
    logic [N*W-1:0] frame_r = '0;
    logic [N*W-1:0] frame_i = '0;
    logic           m_ready = 1'b0;
    logic           ovf_clr = 1'b0;

    logic           frame_ready, m_valid, m_last, overflow;
    logic [W-1:0]   m_data_r, m_data_i;
    logic [IW-1:0]  m_index;

    logic           b_frame_ready, b_m_valid, b_m_last, b_overflow;
    logic [W-1:0]   b_m_data_r, b_m_data_i;
    logic [IW-1:0]  b_m_index;

    int checks = 0;
    int failures = 0;

    logic [N*W-1:0] q_r [$];
    logic [N*W-1:0] q_i [$];
    int             pos = 0;
    bit             ovf_exp = 1'b0;
    bit             stalled = 1'b0;
    logic [W-1:0]   prev_r;
    logic [IW-1:0]  prev_idx;

    fft_frame_serializer #(.N(N), .W(W), .BITREV(0)) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
        .frame_r(frame_r), .frame_i(frame_i), .frame_ready(frame_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data_r(m_data_r),
        .m_data_i(m_data_i), .m_index(m_index), .m_last(m_last),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    fft_frame_serializer #(.N(N), .W(W), .BITREV(1)) dut_br (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
        .frame_r(frame_r), .frame_i(frame_i), .frame_ready(b_frame_ready),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_data_r(b_m_data_r),
        .m_data_i(b_m_data_i), .m_index(b_m_index), .m_last(b_m_last),
        .overflow(b_overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < IW; b++) begin
            if ((v & (1 << b)) != 0) r = r | (1 << (IW - 1 - b));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle. Called at posedge+1 with the inputs already set up.
    task automatic tick();
        bit             ready_exp;
        logic [N*W-1:0] cur_r, cur_i;
        ready_exp = (q_r.size() < 2);
        chk("frame_ready", {31'd0, frame_ready}, {31'd0, ready_exp});
        chk("br_frame_ready", {31'd0, b_frame_ready}, {31'd0, ready_exp});
        if (q_r.size() == 0) chk("idle_valid", {31'd0, m_valid}, 32'd0);
        if (stalled) begin
            chk("hold_data", {16'd0, m_data_r}, {16'd0, prev_r});
            chk("hold_index", {28'd0, m_index}, {28'd0, prev_idx});
        end
        if (m_valid && m_ready && q_r.size() > 0) begin
            cur_r = q_r[0];
            cur_i = q_i[0];
            chk("index", {28'd0, m_index}, pos);
            chk("last", {31'd0, m_last}, {31'd0, (pos == N - 1)});
            chk("data_r", {16'd0, m_data_r}, {16'd0, cur_r[pos*W +: W]});
            chk("data_i", {16'd0, m_data_i}, {16'd0, cur_i[pos*W +: W]});
            chk("br_valid", {31'd0, b_m_valid}, 32'd1);
            chk("br_index", {28'd0, b_m_index}, pos);
            chk("br_data_r", {16'd0, b_m_data_r}, {16'd0, cur_r[brev(pos)*W +: W]});
            chk("br_data_i", {16'd0, b_m_data_i}, {16'd0, cur_i[brev(pos)*W +: W]});
            pos++;
            if (pos == N) begin
                pos = 0;
                void'(q_r.pop_front());
                void'(q_i.pop_front());
            end
        end
        if (frame_valid && ready_exp) begin
            q_r.push_back(frame_r);
            q_i.push_back(frame_i);
        end
        if (frame_valid && !ready_exp) ovf_exp = 1'b1;
        else if (ovf_clr) ovf_exp = 1'b0;
        stalled  = m_valid && !m_ready;
        prev_r   = m_data_r;
        prev_idx = m_index;
        @(posedge clk);
        #1;
        chk("overflow", {31'd0, overflow}, {31'd0, ovf_exp});
        chk("br_overflow", {31'd0, b_overflow}, {31'd0, ovf_exp});
    endtask

    task automatic offer(input logic [N*W-1:0] r, input logic [N*W-1:0] i);
        frame_valid = 1'b1;
        frame_r     = r;
        frame_i     = i;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input bit rnd);
        int n = 0;
        frame_valid = 1'b0;
        while (q_r.size() > 0 && n < max_cycles) begin
            m_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            tick();
            n++;
        end
        if (q_r.size() > 0) chk("drain_timeout", q_r.size(), 32'd0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_ready", {31'd0, frame_ready}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_index", {28'd0, m_index}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_data_r", {16'd0, m_data_r}, 32'd0);
        q_r.delete();
        q_i.delete();
        pos = 0;
        ovf_exp = 1'b0;
        stalled = 1'b0;
        frame_valid = 1'b0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rand_frame();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom);
        return f;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] ramp_r, ramp_i, fa, fb;
        int t, stall, n;

        async_reset();

        // Ramp frame with continuous ready: check latency, then 16 back-to-back beats.
        for (int k = 0; k < N; k++) begin
            ramp_r[k*W +: W] = W'(100 * k);
            ramp_i[k*W +: W] = W'(-k);
        end
        m_ready = 1'b1;
        offer(ramp_r, ramp_i);
        chk("lat_idle", {31'd0, m_valid}, 32'd0);
        tick();
        chk("lat_stream", {31'd0, m_valid}, 32'd1);
        chk("lat_index", {28'd0, m_index}, 32'd0);
        for (int b = 0; b < N; b++) begin
            chk("ramp_valid", {31'd0, m_valid}, 32'd1);
            tick();
        end
        chk("ramp_after", {31'd0, m_valid}, 32'd0);

        // Same frame, ready alternating, plus a 5-cycle stall at index 7.
        offer(ramp_r, ramp_i);
        t = 0;
        stall = 0;
        n = 0;
        while (q_r.size() > 0 && n < 200) begin
            if (m_valid && pos == 7 && stall < 5) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = (t % 2 == 0);
            end
            t++;
            n++;
            tick();
        end
        if (q_r.size() > 0) chk("stall_timeout", q_r.size(), 32'd0);

        // Two frames offered back to back: 32 beats with no gap.
        for (int k = 0; k < N; k++) begin
            fa[k*W +: W] = W'(16'h0100 + k);
            fb[k*W +: W] = W'(16'h0200 + k);
        end
        m_ready = 1'b1;
        offer(fa, fa);
        offer(fb, fb);
        for (int b = 0; b < 2 * N; b++) begin
            chk("b2b_valid", {31'd0, m_valid}, 32'd1);
            tick();
        end
        chk("b2b_after", {31'd0, m_valid}, 32'd0);

        // Output held off: the third frame is dropped, then overflow is cleared.
        m_ready = 1'b0;
        offer(fa, fa);
        offer(fb, fb);
        chk("ready_drop", {31'd0, frame_ready}, 32'd0);
        offer(ramp_r, ramp_i);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        drain(100, 1'b0);

        // Reset in the middle of a frame (while overflow is set), then a fresh frame.
        m_ready = 1'b0;
        offer(fa, fa);
        offer(fb, fb);
        offer(ramp_r, ramp_i);
        m_ready = 1'b1;
        n = 0;
        while (pos != 9 && n < 50) begin
            tick();
            n++;
        end
        chk("reach_beat9", pos, 32'd9);
        async_reset();
        m_ready = 1'b1;
        offer(ramp_r, ramp_i);
        tick();
        chk("post_rst_index", {28'd0, m_index}, 32'd0);
        drain(100, 1'b0);

        // slot k carries bitrev(k): the BITREV instance outputs data equal to the index.
        for (int k = 0; k < N; k++) fa[k*W +: W] = W'(brev(k));
        m_ready = 1'b1;
        offer(fa, rand_frame());
        tick();
        for (int b = 0; b < N; b++) begin
            chk("br_identity", {16'd0, b_m_data_r}, {28'd0, b_m_index});
            tick();
        end

        // Random traffic, random backpressure, occasional clear.
        for (int c = 0; c < 800; c++) begin
            frame_valid = ($urandom_range(3) == 0);
            frame_r     = rand_frame();
            frame_i     = rand_frame();
            m_ready     = ($urandom_range(3) != 0);
            ovf_clr     = ($urandom_range(15) == 0);
            tick();
        end
        frame_valid = 1'b0;
        ovf_clr = 1'b0;
        drain(400, 1'b1);
        tick();
        chk("final_idle", {31'd0, m_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
